cacheline_arbiter: RTL

//  Shares the single physical-memory port between the I-cache (read-only) and D-cache (read/write).

---
 rtl/cacheline_arbiter_pkg.sv | 27 ++
 rtl/cacheline_arbiter_if.sv | 43 ++++
 rtl/cacheline_arbiter_grant_select.sv | 30 +++
 rtl/cacheline_arbiter.sv | 120 ++++++++++++
 4 files changed

// File: rtl/cacheline_arbiter_pkg.sv
// Shared types for the cacheline arbiter: FSM states, transaction owner, pmem op.
package arbiter_types;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BUSY_I,
    ST_BUSY_D,
    ST_RESP_I,
    ST_RESP_D
  } arb_state_t;

  typedef enum logic {
    OWNER_I,
    OWNER_D
  } arb_owner_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } pmem_op_t;

  // Busy state that serves the given owner.
  function automatic arb_state_t busy_state(arb_owner_t owner);
    return (owner == OWNER_D) ? ST_BUSY_D : ST_BUSY_I;
  endfunction

endpackage

// File: rtl/cacheline_arbiter_if.sv
// Bundle of I-cache, D-cache and physical-memory signals around the arbiter.
// slave: arbiter view.  master: environment view (caches + pmem).
interface cacheline_arbiter_if #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32
);
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  i_read, i_address,
    output i_rdata, i_resp,
    input  d_read, d_write, d_address, d_wdata,
    output d_rdata, d_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output i_read, i_address,
    input  i_rdata, i_resp,
    output d_read, d_write, d_address, d_wdata,
    input  d_rdata, d_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/cacheline_arbiter_grant_select.sv
// Combinational grant policy for the cacheline arbiter.
// ARBITER_ROUND_ROBIN_EN: alternate on simultaneous requests using last_owner;
// otherwise D-cache has fixed priority and there is no last_owner input.
module arbiter_grant_select
  import arbiter_types::*;
(
  input  logic       i_req,
  input  logic       d_req,
`ifdef ARBITER_ROUND_ROBIN_EN
  input  arb_owner_t last_owner,
`endif
  output logic       grant_valid,
  output arb_owner_t grant_owner
);

  // Pick the winner; a lone requester always wins.
  always_comb begin
    grant_valid = i_req | d_req;
    grant_owner = OWNER_D;
    if (i_req && !d_req) begin
      grant_owner = OWNER_I;
    end
`ifdef ARBITER_ROUND_ROBIN_EN
    else if (i_req && d_req && last_owner == OWNER_D) begin
      grant_owner = OWNER_I;
    end
`endif
  end

endmodule

// File: rtl/cacheline_arbiter.sv
// Shares one pmem port between I-cache and D-cache, one cacheline at a time.
// Optional ARBITER_ROUND_ROBIN_EN selects round-robin instead of D-over-I priority.
module cacheline_arbiter
  import arbiter_types::*;
#(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32
) (
  input logic                clk,
  input logic                rst,
  cacheline_arbiter_if.slave bus
);

  arb_state_t        state, state_next;
  pmem_op_t          op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] i_line_q;
  logic [LINE_W-1:0] d_line_q;

  logic       i_req, d_req;
  logic       grant_valid, grant;
  arb_owner_t grant_owner;

  assign i_req = bus.i_read;
  assign d_req = bus.d_read | bus.d_write;
  assign grant = (state == ST_IDLE) && grant_valid;

`ifdef ARBITER_ROUND_ROBIN_EN
  arb_owner_t last_owner;

  // Remember who was granted last; starts at I so D wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner <= OWNER_I;
    end else if (grant) begin
      last_owner <= grant_owner;
    end
  end

  arbiter_grant_select u_grant (
    .i_req       (i_req),
    .d_req       (d_req),
    .last_owner  (last_owner),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );
`else
  arbiter_grant_select u_grant (
    .i_req       (i_req),
    .d_req       (d_req),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: grant in IDLE, wait for pmem_resp, one response cycle.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:   if (grant_valid) state_next = busy_state(grant_owner);
      ST_BUSY_I: if (bus.pmem_resp) state_next = ST_RESP_I;
      ST_BUSY_D: if (bus.pmem_resp) state_next = ST_RESP_D;
      ST_RESP_I,
      ST_RESP_D: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Latch the granted request and capture returned lines per owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= OP_READ;
      addr_q   <= '0;
      wdata_q  <= '0;
      i_line_q <= '0;
      d_line_q <= '0;
    end else begin
      if (grant) begin
        if (grant_owner == OWNER_D) begin
          addr_q  <= bus.d_address;
          wdata_q <= bus.d_wdata;
          op_q    <= bus.d_write ? OP_WRITE : OP_READ;
        end else begin
          addr_q  <= bus.i_address;
          op_q    <= OP_READ;
        end
      end
      if (state == ST_BUSY_I && bus.pmem_resp) i_line_q <= bus.pmem_rdata;
      if (state == ST_BUSY_D && bus.pmem_resp) d_line_q <= bus.pmem_rdata;
    end
  end

  logic busy;
  assign busy = (state == ST_BUSY_I) || (state == ST_BUSY_D);

  assign bus.pmem_read    = busy && (op_q == OP_READ);
  assign bus.pmem_write   = busy && (op_q == OP_WRITE);
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wdata_q;
  assign bus.i_rdata      = i_line_q;
  assign bus.d_rdata      = d_line_q;
  assign bus.i_resp       = (state == ST_RESP_I);
  assign bus.d_resp       = (state == ST_RESP_D);

  // A D-cache read and write together is illegal; the write would win.
  a_no_d_read_write: assert property (@(posedge clk) disable iff (rst)
    !(bus.d_read && bus.d_write))
    else $error("d_read and d_write asserted together");

endmodule
